// File: rtl/sobel_gradient_pipe.sv
// sobel_gradient_pipe: three-stage Sobel gradient unit with valid/ready flow
// control, selectable Gx/Gy combine mode, thresholded edge bit and a
// saturating edge counter. `edge` is a reserved word in SystemVerilog, so the
// edge output is named is_edge.
module sobel_gradient_pipe #(
  parameter  int PIXEL_W = 8,
  parameter  int CNT_W   = 20,
  localparam int MAG_W   = PIXEL_W + 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [9*PIXEL_W-1:0] window,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [MAG_W-1:0]     threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAG_W-1:0]     mag,
  output logic                 is_edge,
  output logic                 gx_neg,
  output logic                 gy_neg,
  input  logic                 count_clear,
  output logic [CNT_W-1:0]     edge_count
);

  // A weighted column sum p + 2p + p is at most 4*(2^PIXEL_W-1).
  localparam int SUM_W = PIXEL_W + 2;

  typedef enum logic [1:0] {
    MODE_GX  = 2'b00,
    MODE_GY  = 2'b01,
    MODE_SUM = 2'b10,
    MODE_MAX = 2'b11
  } mode_e;

  // Stage valids and flow control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic out_valid_q, out_valid_d;
  logic s3_free, s2_free, s1_free;
  logic accept, s1_move, s2_move;

  // Stage 1: partial sums plus the sample's own mode and threshold
  logic [PIXEL_W-1:0] px [9];
  logic [SUM_W-1:0]   gx_p_d, gx_m_d, gy_p_d, gy_m_d;
  logic [SUM_W-1:0]   gx_p_q, gx_m_q, gy_p_q, gy_m_q;
  mode_e              s1_mode_q;
  logic [MAG_W-1:0]   s1_thr_q;

  // Stage 2: absolute values and signs
  logic [SUM_W-1:0]   gx_abs_d, gy_abs_d, gx_abs_q, gy_abs_q;
  logic               gx_sgn_d, gy_sgn_d, gx_sgn_q, gy_sgn_q;
  mode_e              s2_mode_q;
  logic [MAG_W-1:0]   s2_thr_q;

  // Stage 3: output registers
  logic [MAG_W-1:0]   ax, ay, mag_d, mag_q;
  logic               edge_d, edge_q, gx_neg_q, gy_neg_q;

  logic [CNT_W-1:0]   edge_count_q, edge_count_d;

  // Flow control: a stage is free when empty or when it empties this cycle
  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    s3_free     = !out_valid_q || out_ready;
    s2_free     = !s2_valid_q || s3_free;
    s1_free     = !s1_valid_q || s2_free;
    s2_move     = s2_valid_q && s3_free;
    s1_move     = s1_valid_q && s2_free;
    accept      = in_valid && s1_free;
    s1_valid_d  = s1_free ? in_valid   : s1_valid_q;
    s2_valid_d  = s2_free ? s1_valid_q : s2_valid_q;
    out_valid_d = s3_free ? s2_valid_q : out_valid_q;
  end

  // Stage valid registers
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!n_rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Unpack the row-major window into individual pixels
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      px[k] = window[k*PIXEL_W +: PIXEL_W];
    end
  end

  // Stage 1 combinational: positive and negative weighted column/row sums
  always_comb begin
    gx_p_d = SUM_W'(px[2]) + (SUM_W'(px[5]) << 1) + SUM_W'(px[8]);
    gx_m_d = SUM_W'(px[0]) + (SUM_W'(px[3]) << 1) + SUM_W'(px[6]);
    gy_p_d = SUM_W'(px[6]) + (SUM_W'(px[7]) << 1) + SUM_W'(px[8]);
    gy_m_d = SUM_W'(px[0]) + (SUM_W'(px[1]) << 1) + SUM_W'(px[2]);
  end

  // Stage 2 combinational: sign of each difference and its magnitude
  always_comb begin
    gx_sgn_d = gx_m_q > gx_p_q;
    gy_sgn_d = gy_m_q > gy_p_q;
    gx_abs_d = gx_sgn_d ? (gx_m_q - gx_p_q) : (gx_p_q - gx_m_q);
    gy_abs_d = gy_sgn_d ? (gy_m_q - gy_p_q) : (gy_p_q - gy_m_q);
  end

  // Stage 1/2 datapath registers, loaded only when their stage takes a sample
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents mean anything.
    if (accept) begin
      gx_p_q    <= gx_p_d;
      gx_m_q    <= gx_m_d;
      gy_p_q    <= gy_p_d;
      gy_m_q    <= gy_m_d;
      s1_mode_q <= mode_e'(mode);
      s1_thr_q  <= threshold;
    end
    if (s1_move) begin
      gx_abs_q  <= gx_abs_d;
      gy_abs_q  <= gy_abs_d;
      gx_sgn_q  <= gx_sgn_d;
      gy_sgn_q  <= gy_sgn_d;
      s2_mode_q <= s1_mode_q;
      s2_thr_q  <= s1_thr_q;
    end
  end

  // Stage 3 combinational: combine per mode and compare against threshold
  always_comb begin
    ax    = MAG_W'(gx_abs_q);
    ay    = MAG_W'(gy_abs_q);
    mag_d = ax;
    case (s2_mode_q)
      MODE_GX:  mag_d = ax;
      MODE_GY:  mag_d = ay;
      MODE_SUM: mag_d = ax + ay;
      MODE_MAX: mag_d = (ax >= ay) ? ax : ay;
      default:  mag_d = ax;
    endcase
    edge_d = mag_d >= s2_thr_q;
  end

  // Stage 3 output registers hold their value until a new sample arrives
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mag_q    <= '0;
      edge_q   <= 1'b0;
      gx_neg_q <= 1'b0;
      gy_neg_q <= 1'b0;
    end else if (s2_move) begin
      mag_q    <= mag_d;
      edge_q   <= edge_d;
      gx_neg_q <= gx_sgn_q;
      gy_neg_q <= gy_sgn_q;
    end
  end

  // Edge counter next state: clear wins, otherwise saturating increment on an edge transfer
  always_comb begin
    edge_count_d = edge_count_q;
    if (count_clear) begin
      edge_count_d = '0;
    end else if (out_valid_q && out_ready && edge_q && (edge_count_q != '1)) begin
      edge_count_d = edge_count_q + 1'b1;
    end
  end

  // Edge counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_count_q <= '0;
    end else begin
      edge_count_q <= edge_count_d;
    end
  end

  assign in_ready   = s1_free;
  assign out_valid  = out_valid_q;
  assign mag        = mag_q;
  assign is_edge    = edge_q;
  assign gx_neg     = gx_neg_q;
  assign gy_neg     = gy_neg_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Directed bench for sobel_gradient_pipe. Expected results are queued when a
// window is accepted and compared when the pipe presents them. The counter is
// narrowed to 2 bits so saturation is reachable.
module tb_sobel_gradient_pipe;

  localparam int PIXEL_W = 8;
  localparam int CNT_W   = 2;
  localparam int MAG_W   = PIXEL_W + 3;
  localparam int WIN_W   = 9 * PIXEL_W;

  typedef struct {
    logic [MAG_W-1:0] mag;
    logic             edg;
    logic             gxn;
    logic             gyn;
    int               acc_cyc;
    bit               chk_lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [WIN_W-1:0] window;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [MAG_W-1:0] threshold;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W-1:0] mag;
  logic             is_edge;
  logic             gx_neg;
  logic             gy_neg;
  logic             count_clear;
  logic [CNT_W-1:0] edge_count;

  sobel_gradient_pipe #(.PIXEL_W(PIXEL_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .window      (window),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .threshold   (threshold),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mag         (mag),
    .is_edge     (is_edge),
    .gx_neg      (gx_neg),
    .gy_neg      (gy_neg),
    .count_clear (count_clear),
    .edge_count  (edge_count)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  exp_t             sb[$];
  logic [CNT_W-1:0] cnt_model = '0;
  logic             saw_stall = 1'b0;
  exp_t             mon_e;
  logic             xfer_edge;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [WIN_W-1:0] win(input int p0, input int p1, input int p2,
                                           input int p3, input int p4, input int p5,
                                           input int p6, input int p7, input int p8);
    int p [9];
    logic [WIN_W-1:0] w;
    p = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
    for (int k = 0; k < 9; k++) w[k*PIXEL_W +: PIXEL_W] = PIXEL_W'(p[k]);
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [WIN_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PIXEL_W +: PIXEL_W] = PIXEL_W'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic exp_t mk(input int m, input bit ed, input bit gxn, input bit gyn, input bit lat);
    exp_t e;
    e.mag = MAG_W'(m); e.edg = ed; e.gxn = gxn; e.gyn = gyn; e.acc_cyc = 0; e.chk_lat = lat;
    return e;
  endfunction

  // Reference Sobel in signed integer arithmetic
  function automatic exp_t model(input logic [WIN_W-1:0] w, input logic [1:0] m, input logic [MAG_W-1:0] t);
    int p [9];
    int gx, gy, ax, ay, r;
    exp_t e;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*PIXEL_W +: PIXEL_W]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (m)
      2'b00:   r = ax;
      2'b01:   r = ay;
      2'b10:   r = ax + ay;
      default: r = (ax > ay) ? ax : ay;
    endcase
    e.mag = MAG_W'(r); e.edg = (r >= int'(t)); e.gxn = (gx < 0); e.gyn = (gy < 0);
    e.acc_cyc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  // Present one window and hold it until accepted; a window driven after edge
  // N is captured at N+1 and must be visible after edge N+3.
  task automatic send(input logic [WIN_W-1:0] w, input logic [1:0] m, input logic [MAG_W-1:0] t, input exp_t e);
    bit acc = 1'b0;
    window = w; mode = m; threshold = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      e.acc_cyc = cyc;
      @(posedge clk); #1;
    end
    if (acc) sb.push_back(e);
    else check("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: compares against the scoreboard head and tracks the counter
  always @(negedge clk) begin
    if (!n_rst) begin
      cnt_model = '0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(!(sb.size() == 3 && !out_ready)));
      if (!in_ready) saw_stall = 1'b1;
      check("edge_count", 32'(edge_count), 32'(cnt_model));
      xfer_edge = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb[0];
          check("mag", 32'(mag), 32'(mon_e.mag));
          check("edge", 32'(is_edge), 32'(mon_e.edg));
          check("gx_neg", 32'(gx_neg), 32'(mon_e.gxn));
          check("gy_neg", 32'(gy_neg), 32'(mon_e.gyn));
          if (out_ready) begin
            if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.acc_cyc), 32'd3);
            xfer_edge = mon_e.edg;
            void'(sb.pop_front());
          end
        end
      end
      if (count_clear) cnt_model = '0;
      else if (xfer_edge && cnt_model != '1) cnt_model = cnt_model + 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIN_W-1:0] wa, wb, wc, wu, w;
    logic [1:0]       m;
    logic [MAG_W-1:0] t;
    exp_t             e;

    wa = win(50, 255, 250, 100, 0, 200, 100, 255, 255);
    wb = win(255, 255, 0, 155, 255, 205, 255, 255, 5);
    wc = win(40, 255, 32, 255, 255, 100, 0, 255, 1);
    wu = win(255, 255, 255, 255, 255, 255, 255, 255, 255);

    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; count_clear = 1'b0;
    mode = 2'b10; threshold = MAG_W'(1); window = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mag", 32'(mag), 32'd0);
    check("rst_edge", 32'(is_edge), 32'd0);
    check("rst_gx_neg", 32'(gx_neg), 32'd0);
    check("rst_gy_neg", 32'(gy_neg), 32'd0);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    n_rst = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // All-zero window, mode sum, threshold 1
    send('0, 2'b10, MAG_W'(1), mk(0, 0, 0, 0, 1));
    in_valid = 1'b0;
    drain();
    check("zero_edge_count", 32'(edge_count), 32'd0);

    // Same window in all four modes on consecutive cycles
    send(wa, 2'b00, MAG_W'(556), mk(555, 0, 0, 0, 1));
    send(wa, 2'b01, MAG_W'(556), mk(55, 0, 0, 0, 1));
    send(wa, 2'b10, MAG_W'(556), mk(610, 1, 0, 0, 1));
    send(wa, 2'b11, MAG_W'(556), mk(555, 0, 0, 0, 1));
    in_valid = 1'b0;
    drain();

    // Negative gradients and threshold boundary
    send(wb, 2'b00, MAG_W'(405), mk(405, 1, 1, 0, 1));
    send(wb, 2'b01, MAG_W'(405), mk(5, 0, 1, 0, 1));
    send(wc, 2'b10, MAG_W'(388), mk(388, 1, 1, 1, 1));
    send(wc, 2'b10, MAG_W'(389), mk(388, 0, 1, 1, 1));
    in_valid = 1'b0;
    drain();

    // Uniform window gives zero gradient in every mode
    for (int i = 0; i < 4; i++) send(wu, 2'(i), MAG_W'(1), mk(0, 0, 0, 0, 1));
    in_valid = 1'b0;
    drain();

    // Stream with out_ready toggling 1,0,0,...
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          w = rand_win();
          m = 2'($urandom_range(0, 3));
          t = MAG_W'($urandom_range(0, 1200));
          e = model(w, m, t);
          send(w, m, t, e);
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 45; i++) begin
          out_ready = (i % 3 == 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_seen", 32'(saw_stall), 32'd1);

    // Counter saturation
    count_clear = 1'b1;
    @(posedge clk); #1;
    count_clear = 1'b0;
    check("clear_count", 32'(edge_count), 32'd0);
    for (int i = 0; i < 5; i++) send(wa, 2'b10, MAG_W'(0), mk(610, 1, 0, 0, 1));
    in_valid = 1'b0;
    drain();
    check("sat_count", 32'(edge_count), 32'd3);

    // Clear on the same cycle as an edge transfer
    out_ready = 1'b0;
    send(wa, 2'b10, MAG_W'(0), mk(610, 1, 0, 0, 0));
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("stalled_out_valid", 32'(out_valid), 32'd1);
    count_clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    count_clear = 1'b0;
    check("clear_priority", 32'(edge_count), 32'd0);
    drain();

    // Make the counter nonzero, then reset with three samples in flight
    send(wa, 2'b10, MAG_W'(0), mk(610, 1, 0, 0, 1));
    in_valid = 1'b0;
    drain();
    check("pre_reset_count", 32'(edge_count), 32'd1);
    for (int i = 0; i < 3; i++) send(wa, 2'b00, MAG_W'(2040), mk(555, 0, 0, 0, 1));
    in_valid = 1'b0;
    n_rst = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_edge_count", 32'(edge_count), 32'd0);
    check("midrst_mag", 32'(mag), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("post_rst_quiet", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
